boundary_scan_register: RTL and testbench

- Boundary-scan data register chain for the JTAG block.
- Sits directly downstream of the JTAG top level: consumes `bsr_tdi` and the TAP control strobes, and returns `bsr_tdo` for the TDO mux.
- Each boundary cell has a shift stage and an update stage. The chain observes pad inputs and core outputs, and can override pad outputs (EXTEST) or core inputs (INTEST) from the update stages.
- A shift counter reports how many bits were shifted since the last capture, so software and the bench can check chain length.

---
 rtl/jtag_pkg.sv | 13 +
 rtl/bsr_cell.sv | 45 ++++
 rtl/boundary_scan_register.sv | 93 +++++++++
 tb/tb_boundary_scan_register.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: boundary-scan instruction modes.
package jtag_pkg;

  localparam int unsigned BSR_MODE_W = 2;

  // 2'b11 is reserved and decodes to none of these, so it acts as SAMPLE.
  typedef enum logic [BSR_MODE_W-1:0] {
    BSR_SAMPLE = 2'b00,
    BSR_EXTEST = 2'b01,
    BSR_INTEST = 2'b10
  } bsr_mode_t;

endpackage

// File: rtl/bsr_cell.sv
// One boundary-scan cell: a shift stage and an update stage.
module bsr_cell (
  input  logic tck_i,
  input  logic trst_i,
  input  logic cap_val_i,
  input  logic si_i,
  output logic so_o,
  input  logic capture_i,
  input  logic shift_i,
  input  logic update_i,
  output logic upd_o
);

  logic sr_q, sr_d;
  logic upd_q, upd_d;

  // Next state: capture beats shift; update samples the pre-edge shift stage.
  always_comb begin
    sr_d  = sr_q;
    upd_d = upd_q;
    if (capture_i) begin
      sr_d = cap_val_i;
    end else if (shift_i) begin
      sr_d = si_i;
    end
    if (update_i) begin
      upd_d = sr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      sr_q  <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      upd_q <= upd_d;
    end
  end

  assign so_o  = sr_q;
  assign upd_o = upd_q;

endmodule

// File: rtl/boundary_scan_register.sv
// Boundary-scan data register chain with shift counter and pad/core override muxes.
// Optional feature: define BSR_INTEST_EN to let INTEST drive core_in from the update stages.
module boundary_scan_register
  import jtag_pkg::*;
#(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  bsr_sel,
  input  logic [BSR_MODE_W-1:0] bsr_mode,
  input  logic                  captureDR,
  input  logic                  shiftDR,
  input  logic                  updateDR,
  input  logic                  bsr_tdi,
  output logic                  bsr_tdo,
  input  logic [IN_W-1:0]       pad_in,
  output logic [IN_W-1:0]       core_in,
  input  logic [OUT_W-1:0]      core_out,
  output logic [OUT_W-1:0]      pad_out,
  output logic [CNT_W-1:0]      shift_cnt,
  output logic                  len_ok
);

  localparam int unsigned N = IN_W + OUT_W;

  logic         cap_en, shift_en, upd_en;
  logic [N-1:0] cap_vec, si_vec, sr, upd;
  bsr_mode_t    mode;

  assign cap_en   = bsr_sel & captureDR;
  assign shift_en = bsr_sel & shiftDR & ~captureDR;
  assign upd_en   = bsr_sel & updateDR;

  // Input cells sit at the TDO end of the chain, output cells at the TDI end.
  assign cap_vec = {core_out, pad_in};
  assign si_vec  = {bsr_tdi, sr[N-1:1]};

  for (genvar i = 0; i < N; i++) begin : g_cell
    bsr_cell u_cell (
      .tck_i     (tck),
      .trst_i    (trst),
      .cap_val_i (cap_vec[i]),
      .si_i      (si_vec[i]),
      .so_o      (sr[i]),
      .capture_i (cap_en),
      .shift_i   (shift_en),
      .update_i  (upd_en),
      .upd_o     (upd[i])
    );
  end

  assign bsr_tdo = sr[0];

  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;

  // Shift counter: cleared by capture, saturating increment on each shift.
  always_comb begin
    shift_cnt_d = shift_cnt_q;
    if (cap_en) begin
      shift_cnt_d = '0;
    end else if (shift_en && (shift_cnt_q != '1)) begin
      shift_cnt_d = shift_cnt_q + CNT_W'(1);
    end
  end

  // Shift counter register with synchronous reset.
  always_ff @(posedge tck) begin
    if (trst) begin
      shift_cnt_q <= '0;
    end else begin
      shift_cnt_q <= shift_cnt_d;
    end
  end

  assign shift_cnt = shift_cnt_q;
  assign len_ok    = (shift_cnt_q == CNT_W'(N));

  assign mode    = bsr_mode_t'(bsr_mode);
  assign pad_out = (bsr_sel && (mode == BSR_EXTEST)) ? upd[N-1:IN_W] : core_out;

`ifdef BSR_INTEST_EN
  assign core_in = (bsr_sel && (mode == BSR_INTEST)) ? upd[IN_W-1:0] : pad_in;
`else
  // Input-cell update stages still exist for the chain but drive nothing.
  logic unused_upd_in;
  assign unused_upd_in = ^upd[IN_W-1:0];
  assign core_in = pad_in;
`endif

endmodule

// File: tb/tb_boundary_scan_register.sv
// Self-checking bench for boundary_scan_register (IN_W=2, OUT_W=2).
module tb_boundary_scan_register;

  logic        tck;
  logic        trst;
  logic        bsr_sel;
  logic [1:0]  bsr_mode;
  logic        captureDR, shiftDR, updateDR, bsr_tdi;
  logic [1:0]  pad_in, core_out;
  logic        bsr_tdo;
  logic [1:0]  core_in, pad_out;
  logic [15:0] shift_cnt;
  logic        len_ok;

  logic        sat_tdo;
  logic [1:0]  sat_core_in, sat_pad_out;
  logic [2:0]  sat_cnt;
  logic        sat_len_ok;

  int checks   = 0;
  int failures = 0;

  boundary_scan_register #(.IN_W(2), .OUT_W(2), .CNT_W(16)) dut (
    .tck       (tck),
    .trst      (trst),
    .bsr_sel   (bsr_sel),
    .bsr_mode  (bsr_mode),
    .captureDR (captureDR),
    .shiftDR   (shiftDR),
    .updateDR  (updateDR),
    .bsr_tdi   (bsr_tdi),
    .bsr_tdo   (bsr_tdo),
    .pad_in    (pad_in),
    .core_in   (core_in),
    .core_out  (core_out),
    .pad_out   (pad_out),
    .shift_cnt (shift_cnt),
    .len_ok    (len_ok)
  );

  // Narrow counter instance for saturation checks.
  boundary_scan_register #(.IN_W(2), .OUT_W(2), .CNT_W(3)) dut_sat (
    .tck       (tck),
    .trst      (trst),
    .bsr_sel   (bsr_sel),
    .bsr_mode  (bsr_mode),
    .captureDR (captureDR),
    .shiftDR   (shiftDR),
    .updateDR  (updateDR),
    .bsr_tdi   (bsr_tdi),
    .bsr_tdo   (sat_tdo),
    .pad_in    (pad_in),
    .core_in   (sat_core_in),
    .core_out  (core_out),
    .pad_out   (sat_pad_out),
    .shift_cnt (sat_cnt),
    .len_ok    (sat_len_ok)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  typedef struct packed {
    logic        trst;
    logic        sel;
    logic [1:0]  mode;
    logic        cap;
    logic        shf;
    logic        upd;
    logic        tdi;
    logic [1:0]  pad;
    logic [1:0]  cout;
    logic        e_tdo;
    logic [15:0] e_cnt;
    logic        e_len;
    logic [1:0]  e_pout;
    logic [1:0]  e_cin;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic idle();
    trst = 1'b0; captureDR = 1'b0; shiftDR = 1'b0; updateDR = 1'b0; bsr_tdi = 1'b0;
  endtask

  initial begin
    // trst sel mode cap shf upd tdi pad cout | tdo cnt len pout cin
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 16'd1, 1'b0, 2'b01, 2'b10};
    vecs[1]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 16'd2, 1'b0, 2'b01, 2'b10};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 16'd3, 1'b0, 2'b01, 2'b10};
    // reset mid-shift clears sr, upd and counter; EXTEST then shows cleared upd
    vecs[3]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 16'd0, 1'b0, 2'b00, 2'b10};
    vecs[4]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 16'd0, 1'b0, 2'b01, 2'b10};
    // SAMPLE: capture {core_out,pad_in}=0110, then shift out
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 16'd0, 1'b0, 2'b01, 2'b10};
    vecs[6]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b1, 16'd1, 1'b0, 2'b01, 2'b10};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b1, 16'd2, 1'b0, 2'b01, 2'b10};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 16'd3, 1'b0, 2'b01, 2'b10};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 16'd4, 1'b1, 2'b01, 2'b10};
    // PRELOAD 1100 (tdi 0,0,1,1); len_ok drops past N
    vecs[10] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 16'd5, 1'b0, 2'b01, 2'b10};
    vecs[11] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 16'd6, 1'b0, 2'b01, 2'b10};
    vecs[12] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 16'd7, 1'b0, 2'b01, 2'b10};
    vecs[13] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 16'd8, 1'b0, 2'b01, 2'b10};
    vecs[14] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 16'd8, 1'b0, 2'b01, 2'b10};
    vecs[15] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 16'd8, 1'b0, 2'b11, 2'b10};
    // deselected: muxes fall back, all strobes ignored
    vecs[16] = '{1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 16'd8, 1'b0, 2'b01, 2'b10};
    vecs[17] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 16'd8, 1'b0, 2'b11, 2'b10};
    // reserved mode acts as SAMPLE
    vecs[18] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 16'd8, 1'b0, 2'b01, 2'b10};
    // capture beats shift
    vecs[19] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 16'd0, 1'b0, 2'b01, 2'b10};
    // update with shift latches pre-shift sr 0110; sr becomes 1011
    vecs[20] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 16'd1, 1'b0, 2'b01, 2'b10};
    vecs[21] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 16'd1, 1'b0, 2'b10, 2'b10};

    idle();
    bsr_sel = 1'b0; bsr_mode = 2'b00; pad_in = 2'b10; core_out = 2'b01;
    trst = 1'b1;
    tick();
    tick();
    chk("reset_tdo", int'(bsr_tdo), 0);
    chk("reset_cnt", int'(shift_cnt), 0);
    chk("reset_len_ok", int'(len_ok), 0);
    chk("reset_pad_out", int'(pad_out), 1);
    chk("reset_core_in", int'(core_in), 2);
    trst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      trst      = vecs[i].trst;
      bsr_sel   = vecs[i].sel;
      bsr_mode  = vecs[i].mode;
      captureDR = vecs[i].cap;
      shiftDR   = vecs[i].shf;
      updateDR  = vecs[i].upd;
      bsr_tdi   = vecs[i].tdi;
      pad_in    = vecs[i].pad;
      core_out  = vecs[i].cout;
      tick();
      chk($sformatf("vec%0d_tdo", i), int'(bsr_tdo), int'(vecs[i].e_tdo));
      chk($sformatf("vec%0d_cnt", i), int'(shift_cnt), int'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_len_ok", i), int'(len_ok), int'(vecs[i].e_len));
      chk($sformatf("vec%0d_pad_out", i), int'(pad_out), int'(vecs[i].e_pout));
      chk($sformatf("vec%0d_core_in", i), int'(core_in), int'(vecs[i].e_cin));
    end

    // INTEST: preload 0011 (sr 1011 -> 1101 -> 1110 -> 0111 -> 0011)
    idle();
    bsr_sel = 1'b1; bsr_mode = 2'b00; pad_in = 2'b00; core_out = 2'b01;
    shiftDR = 1'b1;
    bsr_tdi = 1'b1; tick();
    bsr_tdi = 1'b1; tick();
    bsr_tdi = 1'b0; tick();
    bsr_tdi = 1'b0; tick();
    chk("intest_preload_tdo", int'(bsr_tdo), 1);
    chk("intest_preload_cnt", int'(shift_cnt), 5);
    shiftDR = 1'b0; updateDR = 1'b1; tick();
    updateDR = 1'b0;
    bsr_mode = 2'b10;
    #1;
`ifdef BSR_INTEST_EN
    chk("intest_core_in", int'(core_in), 3);
`else
    chk("intest_core_in", int'(core_in), 0);
`endif
    chk("intest_pad_out", int'(pad_out), 1);
    bsr_sel = 1'b0;
    #1;
    chk("intest_desel_core_in", int'(core_in), 0);

    // Saturation on the 3-bit counter instance.
    bsr_sel = 1'b1; bsr_mode = 2'b00;
    captureDR = 1'b1; tick();
    captureDR = 1'b0;
    chk("sat_capture_cnt", int'(sat_cnt), 0);
    shiftDR = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("sat_cnt4", int'(sat_cnt), 4);
    chk("sat_len_ok4", int'(sat_len_ok), 1);
    for (int k = 0; k < 3; k++) tick();
    chk("sat_cnt7", int'(sat_cnt), 7);
    for (int k = 0; k < 3; k++) tick();
    shiftDR = 1'b0;
    chk("sat_cnt10", int'(sat_cnt), 7);
    chk("sat_len_ok10", int'(sat_len_ok), 0);
    chk("wide_cnt10", int'(shift_cnt), 10);
    chk("wide_len_ok10", int'(len_ok), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
